// File: rtl/cr_kme_hmac_feeder_pkg.sv
// Shared types and helpers for the KME HMAC input feeder.
package cr_kme_hmac_feeder_pkg;

    localparam int BEAT_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        KEY,
        LEN,
        DATA,
        DONE
    } state_e;

    // Byte 0 lives in [127:120]; bytes at index >= num_bytes are cleared.
    function automatic logic [127:0] byte_mask(input logic [4:0] num_bytes);
        logic [127:0] mask;
        mask = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (i < int'(num_bytes)) mask[127-8*i -: 8] = 8'hFF;
        end
        return mask;
    endfunction

endpackage

// File: rtl/cr_kme_hmac_beat_fmt.sv
// Combinational beat formatter: remaining byte count -> byte count, eof, masked data.
module cr_kme_hmac_beat_fmt
    import cr_kme_hmac_feeder_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic [LEN_W-1:0] rem,
    input  logic [127:0]     src_data,
    output logic [4:0]       num_bytes,
    output logic             eof,
    output logic [127:0]     data
);

    always_comb begin
        num_bytes = (rem >= LEN_W'(BEAT_BYTES)) ? 5'(BEAT_BYTES) : rem[4:0];
        eof       = (rem <= LEN_W'(BEAT_BYTES));
        data      = src_data & byte_mask(num_bytes);
    end

endmodule

// File: rtl/cr_kme_hmac_feeder.sv
// Drives the HMAC engine command/key/length/data channels for one request at a time.
module cr_kme_hmac_feeder
    import cr_kme_hmac_feeder_pkg::*;
#(
    parameter int SMALL_SIZE_BYTES = 64,
    parameter int LEN_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic             scan_mode,
    input  logic             scan_rst_n,
    input  logic             req_valid,
    input  logic             req_skip,
    input  logic             req_eoc,
    input  logic [255:0]     req_key,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ack,
    input  logic [127:0]     src_data,
    input  logic             src_valid,
    output logic             src_rd,
    output logic             cmdfifo_hash_valid,
    output logic             cmdfifo_hash_skip,
    output logic             cmdfifo_hash_small_size,
    input  logic             hash_cmdfifo_ack,
    output logic [255:0]     keyfifo_hash_data,
    output logic             keyfifo_hash_valid,
    input  logic             hash_keyfifo_ack,
    output logic [LEN_W-1:0] hash_len_data_out,
    output logic             hash_len_data_out_valid,
    input  logic             hash_len_data_out_ack,
    output logic             in_hash_valid,
    output logic             in_hash_eof,
    output logic             in_hash_eoc,
    output logic [4:0]       in_hash_num_bytes,
    output logic [127:0]     in_hash_data,
    input  logic             hash_in_stall,
    output logic             busy,
    output logic             done
);

    logic rst_n_int;
    logic unused_scan_en;
    assign rst_n_int      = scan_mode ? scan_rst_n : rst_n;
    assign unused_scan_en = scan_en;

    state_e             state_q, state_d;
    logic [255:0]       key_q, key_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               skip_q, skip_d;
    logic               eoc_q, eoc_d;
    logic               small_q, small_d;
    logic               empty_q, empty_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               key_valid_q, key_valid_d;
    logic               len_valid_q, len_valid_d;

    logic [4:0]   fmt_num_bytes;
    logic         fmt_eof;
    logic [127:0] fmt_data;
    logic         xfer;

    cr_kme_hmac_beat_fmt #(.LEN_W(LEN_W)) u_beat_fmt (
        .rem       (rem_q),
        .src_data  (src_data),
        .num_bytes (fmt_num_bytes),
        .eof       (fmt_eof),
        .data      (fmt_data)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        len_d   = len_q;
        rem_d   = rem_q;
        skip_d  = skip_q;
        eoc_d   = eoc_q;
        small_d = small_q;
        empty_d = empty_q;
        req_ack = 1'b0;

        // An empty message sends one zero-length beat without touching src.
        in_hash_valid = (state_q == DATA) & (empty_q | (src_valid & (rem_q != '0)));
        xfer          = in_hash_valid & ~hash_in_stall;
        src_rd        = xfer & ~empty_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ack = 1'b1;
                    key_d   = req_key;
                    len_d   = req_len;
                    rem_d   = req_len;
                    skip_d  = req_skip;
                    eoc_d   = req_eoc;
                    small_d = (req_len <= LEN_W'(SMALL_SIZE_BYTES));
                    empty_d = (req_len == '0);
                    state_d = CMD;
                end
            end
            CMD:  if (cmd_valid_q & hash_cmdfifo_ack) state_d = skip_q ? DONE : KEY;
            KEY:  if (key_valid_q & hash_keyfifo_ack) state_d = LEN;
            LEN:  if (len_valid_q & hash_len_data_out_ack) state_d = DATA;
            DATA: begin
                if (xfer) begin
                    rem_d = (rem_q > LEN_W'(BEAT_BYTES)) ? rem_q - LEN_W'(BEAT_BYTES) : '0;
                    if (fmt_eof) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_valid_d = (state_d == CMD);
        key_valid_d = (state_d == KEY);
        len_valid_d = (state_d == LEN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // Key and length are reset too because they drive ports that must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= IDLE;
            key_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            skip_q      <= 1'b0;
            eoc_q       <= 1'b0;
            small_q     <= 1'b0;
            empty_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            key_valid_q <= 1'b0;
            len_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            skip_q      <= skip_d;
            eoc_q       <= eoc_d;
            small_q     <= small_d;
            empty_q     <= empty_d;
            cmd_valid_q <= cmd_valid_d;
            key_valid_q <= key_valid_d;
            len_valid_q <= len_valid_d;
        end
    end

    assign cmdfifo_hash_valid      = cmd_valid_q;
    assign cmdfifo_hash_skip       = cmd_valid_q & skip_q;
    assign cmdfifo_hash_small_size = cmd_valid_q & small_q;
    assign keyfifo_hash_valid      = key_valid_q;
    assign keyfifo_hash_data       = key_q;
    assign hash_len_data_out_valid = len_valid_q;
    assign hash_len_data_out       = len_q;

    assign in_hash_eof       = in_hash_valid & fmt_eof;
    assign in_hash_eoc       = in_hash_eof & eoc_q;
    assign in_hash_num_bytes = in_hash_valid ? fmt_num_bytes : 5'd0;
    assign in_hash_data      = in_hash_valid ? fmt_data : 128'd0;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_cr_kme_hmac_feeder.sv
// Self-checking bench for cr_kme_hmac_feeder against a per-request transaction model.
module tb_cr_kme_hmac_feeder;

    logic         clk;
    logic         rst_n;
    logic         scan_en;
    logic         scan_mode;
    logic         scan_rst_n;
    logic         req_valid;
    logic         req_skip;
    logic         req_eoc;
    logic [255:0] req_key;
    logic [31:0]  req_len;
    logic         req_ack;
    logic [127:0] src_data;
    logic         src_valid;
    logic         src_rd;
    logic         cmdfifo_hash_valid;
    logic         cmdfifo_hash_skip;
    logic         cmdfifo_hash_small_size;
    logic         hash_cmdfifo_ack;
    logic [255:0] keyfifo_hash_data;
    logic         keyfifo_hash_valid;
    logic         hash_keyfifo_ack;
    logic [31:0]  hash_len_data_out;
    logic         hash_len_data_out_valid;
    logic         hash_len_data_out_ack;
    logic         in_hash_valid;
    logic         in_hash_eof;
    logic         in_hash_eoc;
    logic [4:0]   in_hash_num_bytes;
    logic [127:0] in_hash_data;
    logic         hash_in_stall;
    logic         busy;
    logic         done;

    int n_tests;
    int n_fail;

    cr_kme_hmac_feeder #(.SMALL_SIZE_BYTES(64), .LEN_W(32)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .scan_en                 (scan_en),
        .scan_mode               (scan_mode),
        .scan_rst_n              (scan_rst_n),
        .req_valid               (req_valid),
        .req_skip                (req_skip),
        .req_eoc                 (req_eoc),
        .req_key                 (req_key),
        .req_len                 (req_len),
        .req_ack                 (req_ack),
        .src_data                (src_data),
        .src_valid               (src_valid),
        .src_rd                  (src_rd),
        .cmdfifo_hash_valid      (cmdfifo_hash_valid),
        .cmdfifo_hash_skip       (cmdfifo_hash_skip),
        .cmdfifo_hash_small_size (cmdfifo_hash_small_size),
        .hash_cmdfifo_ack        (hash_cmdfifo_ack),
        .keyfifo_hash_data       (keyfifo_hash_data),
        .keyfifo_hash_valid      (keyfifo_hash_valid),
        .hash_keyfifo_ack        (hash_keyfifo_ack),
        .hash_len_data_out       (hash_len_data_out),
        .hash_len_data_out_valid (hash_len_data_out_valid),
        .hash_len_data_out_ack   (hash_len_data_out_ack),
        .in_hash_valid           (in_hash_valid),
        .in_hash_eof             (in_hash_eof),
        .in_hash_eoc             (in_hash_eoc),
        .in_hash_num_bytes       (in_hash_num_bytes),
        .in_hash_data            (in_hash_data),
        .hash_in_stall           (hash_in_stall),
        .busy                    (busy),
        .done                    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bytes carried by beat b of an L-byte message.
    function automatic int beat_bytes(input int len, input int b);
        int r;
        r = len - 16 * b;
        return (r > 16) ? 16 : r;
    endfunction

    function automatic logic [127:0] keep_bytes(input logic [127:0] w, input int n);
        logic [127:0] r;
        r = w;
        for (int b = 0; b < 16; b++) begin
            if (b >= n) r[127-8*b -: 8] = 8'h00;
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: acks high, no stall, src always ready; 1: random acks/stall/gaps;
    // 2: acks high, stall toggling every other cycle, random src gaps.
    task automatic run_req(input int len, input bit skip, input bit eoc, input int mode,
                           input int abort_after);
        logic [127:0] words[$];
        logic [255:0] key;
        int nbeats, nwords, phase, beat, idx, pops, cyc, nb;
        bit exp_v, exp_rd, last;

        nwords = skip ? 0 : (len + 15) / 16;
        nbeats = skip ? 0 : ((len == 0) ? 1 : nwords);
        words.delete();
        for (int i = 0; i < nwords; i++) words.push_back(rand128());
        key   = {rand128(), rand128()};
        beat  = 0;
        idx   = 0;
        pops  = 0;
        cyc   = 0;

        @(negedge clk);
        req_valid = 1'b1;
        req_key   = key;
        req_len   = len;
        req_skip  = skip;
        req_eoc   = eoc;
        src_valid = 1'b0;
        hash_in_stall = 1'b0;
        #1;
        check("req_ack", req_ack, 1'b1);
        check("busy_idle", busy, 1'b0);
        @(posedge clk);
        phase = 1;

        while (phase != 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (abort_after >= 0 && phase == 4 && beat == abort_after) begin
                req_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_outs", {cmdfifo_hash_valid, keyfifo_hash_valid, hash_len_data_out_valid,
                                   in_hash_valid, src_rd, done, busy, req_ack}, 8'd0);
                check("rst_len_key", {hash_len_data_out, keyfifo_hash_data[31:0]}, 64'd0);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            req_valid = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_key   = {rand128(), rand128()};
            if (mode == 1) begin
                hash_cmdfifo_ack      = 1'($urandom_range(0, 1));
                hash_keyfifo_ack      = 1'($urandom_range(0, 1));
                hash_len_data_out_ack = 1'($urandom_range(0, 1));
                hash_in_stall         = ($urandom_range(0, 2) == 0);
            end else begin
                hash_cmdfifo_ack      = 1'b1;
                hash_keyfifo_ack      = 1'b1;
                hash_len_data_out_ack = 1'b1;
                hash_in_stall         = (mode == 2) ? 1'(cyc % 2) : 1'b0;
            end
            src_valid = (idx < nwords) && (mode == 0 || $urandom_range(0, 3) != 0);
            src_data  = (idx < nwords) ? words[idx] : rand128();
            #1;

            check("req_ack_busy", req_ack, 1'b0);
            check("busy", busy, 1'b1);
            check("valids", {cmdfifo_hash_valid, keyfifo_hash_valid, hash_len_data_out_valid},
                  {phase == 1, phase == 2, phase == 3});
            check("done", done, phase == 5);
            exp_v  = (phase == 4) && (len == 0 || src_valid);
            exp_rd = exp_v && !hash_in_stall && (len != 0);
            check("in_hash_valid", in_hash_valid, exp_v);
            check("src_rd", src_rd, exp_rd);
            if (src_rd) pops++;

            case (phase)
                1: begin
                    check("cmd_flags", {cmdfifo_hash_skip, cmdfifo_hash_small_size},
                          {skip, len <= 64});
                    if (hash_cmdfifo_ack) phase = skip ? 5 : 2;
                end
                2: begin
                    check("key", keyfifo_hash_data, key);
                    if (hash_keyfifo_ack) phase = 3;
                end
                3: begin
                    check("len", hash_len_data_out, len);
                    if (hash_len_data_out_ack) phase = 4;
                end
                4: begin
                    if (exp_v) begin
                        nb   = beat_bytes(len, beat);
                        last = (beat == nbeats - 1);
                        check("num_bytes", in_hash_num_bytes, nb);
                        check("eof_eoc", {in_hash_eof, in_hash_eoc}, {last, last && eoc});
                        check("data", in_hash_data, (len == 0) ? 128'd0 : keep_bytes(words[idx], nb));
                        if (!hash_in_stall) begin
                            beat++;
                            if (len != 0) idx++;
                            if (last) phase = 5;
                        end
                    end
                end
                default: phase = 0;
            endcase
            @(posedge clk);
        end
        if (phase != 0) check("timeout", 1'b0, 1'b1);
        check("pops", pops, nwords);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        scan_en = 1'b0;
        scan_mode = 1'b0;
        scan_rst_n = 1'b1;
        req_valid = 1'b0;
        req_skip = 1'b0;
        req_eoc = 1'b0;
        req_key = '0;
        req_len = '0;
        src_data = '0;
        src_valid = 1'b0;
        hash_cmdfifo_ack = 1'b0;
        hash_keyfifo_ack = 1'b0;
        hash_len_data_out_ack = 1'b0;
        hash_in_stall = 1'b0;
        #23;
        check("reset_ctrl", {req_ack, src_rd, cmdfifo_hash_valid, cmdfifo_hash_skip,
                             cmdfifo_hash_small_size, keyfifo_hash_valid, hash_len_data_out_valid,
                             in_hash_valid, in_hash_eof, in_hash_eoc, in_hash_num_bytes, busy, done},
              17'd0);
        check("reset_data", {keyfifo_hash_data[127:0], in_hash_data}, 256'd0);
        check("reset_len", hash_len_data_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(40, 1'b0, 1'b1, 0, -1);
        run_req(16, 1'b0, 1'b0, 0, -1);
        run_req(17, 1'b0, 1'b1, 0, -1);
        run_req(100, 1'b1, 1'b0, 0, -1);
        run_req(0, 1'b0, 1'b1, 0, -1);
        run_req(64, 1'b0, 1'b0, 2, -1);
        run_req(65, 1'b0, 1'b1, 2, -1);
        run_req(48, 1'b0, 1'b0, 0, 1);
        run_req(33, 1'b0, 1'b1, 0, -1);
        for (int i = 0; i < 25; i++) begin
            run_req(int'($urandom_range(0, 100)), ($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 1)), 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
